vend_ctrl_param: RTL and testbench

//  Parametrised coin vending controller: accumulates 1/2/5-unit coins, vends once credit reaches PRICE.

---
 rtl/vend_ctrl_param_pkg.sv | 23 ++
 rtl/vend_ctrl_param_coin_arbiter.sv | 31 +++
 rtl/vend_ctrl_param.sv | 154 +++++++++++++++
 tb/tb_vend_ctrl_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_ctrl_param_pkg.sv
// Shared types and default parameters for the coin vending controller.
// No logic; pure definitions.
// No flow control; consumed at elaboration only.
package vend_ctrl_param_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VEND   = 2'd1,
      ST_PAYOUT = 2'd2
   } state_t;

   localparam int DEF_PRICE    = 5;
   localparam int DEF_CREDIT_W = 4;
   localparam int DEF_VAL_A    = 1;
   localparam int DEF_VAL_B    = 2;
   localparam int DEF_VAL_C    = 5;

   // Largest credit the register of width w can hold.
   function automatic int max_credit(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/vend_ctrl_param_coin_arbiter.sv
// Priority select among simultaneous coin pulses (c > b > a).
// Latency: purely combinational.
// No backpressure; the caller decides whether the selected coin is accepted.
module vend_ctrl_param_coin_arbiter #(
   parameter int W     = 4,
   parameter int VAL_A = 1,
   parameter int VAL_B = 2,
   parameter int VAL_C = 5
) (
   input  logic         coin_a,
   input  logic         coin_b,
   input  logic         coin_c,
   output logic [W-1:0] val,
   output logic         hit,
   output logic         multi
);

   // Highest-value coin wins; more than one pulse means the losers are returned.
   always_comb begin
      val = '0;
      if (coin_c)
         val = W'(VAL_C);
      else if (coin_b)
         val = W'(VAL_B);
      else if (coin_a)
         val = W'(VAL_A);
      hit   = coin_a | coin_b | coin_c;
      multi = (coin_a & coin_b) | (coin_a & coin_c) | (coin_b & coin_c);
   end

endmodule

// File: rtl/vend_ctrl_param.sv
// Coin vending controller: accumulates credit, vends at PRICE, pays change/refund as 2- then 1-unit coins.
// Latency: every response is registered and appears the cycle after its cause.
// While busy (VEND/PAYOUT) all coins are rejected and cancel is ignored.
module vend_ctrl_param
   import vend_ctrl_param_pkg::*;
#(
   parameter int PRICE    = DEF_PRICE,
   parameter int CREDIT_W = DEF_CREDIT_W,
   parameter int VAL_A    = DEF_VAL_A,
   parameter int VAL_B    = DEF_VAL_B,
   parameter int VAL_C    = DEF_VAL_C
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_a,
   input  logic                coin_b,
   input  logic                coin_c,
   input  logic                cancel,
   output logic                vend,
   output logic                chg_1,
   output logic                chg_2,
   output logic                coin_reject,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit
);

   localparam int MAX_CREDIT = max_credit(CREDIT_W);

   // Constants sized to the datapath so comparisons stay width-exact.
   localparam logic [CREDIT_W:0]   MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W:0]   PRICE_S = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W-1:0] VAL_A_W = CREDIT_W'(VAL_A);
   localparam logic [CREDIT_W-1:0] VAL_B_W = CREDIT_W'(VAL_B);

   // Parameter sanity: price range, and a valid coin on top of any sub-price credit must fit.
   generate
      if (PRICE < 1 || PRICE > MAX_CREDIT - 5) begin : g_bad_price
         $error("vend_ctrl_param: PRICE out of range for CREDIT_W");
      end
      if (PRICE + VAL_C - 1 > MAX_CREDIT) begin : g_bad_coin
         $error("vend_ctrl_param: PRICE+VAL_C-1 exceeds credit register");
      end
   endgenerate

   state_t              state;
   logic [CREDIT_W-1:0] payout;

   logic [CREDIT_W-1:0] coin_val;
   logic                coin_hit;
   logic                coin_multi;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W:0]   change;
   logic                pay_big;
   logic [CREDIT_W-1:0] pay_next;

   vend_ctrl_param_coin_arbiter #(
      .W     (CREDIT_W),
      .VAL_A (VAL_A),
      .VAL_B (VAL_B),
      .VAL_C (VAL_C)
   ) u_arb (
      .coin_a (coin_a),
      .coin_b (coin_b),
      .coin_c (coin_c),
      .val    (coin_val),
      .hit    (coin_hit),
      .multi  (coin_multi)
   );

   // Candidate credit with one extra bit so an overflowing coin is detected, not wrapped.
   assign sum    = {1'b0, credit} + {1'b0, coin_val};
   assign change = sum - PRICE_S;

   // Next payout after ejecting one coin; a residue smaller than VAL_A is dropped rather than underflowing.
   always_comb begin
      pay_big = (payout >= VAL_B_W);
      if (pay_big)
         pay_next = payout - VAL_B_W;
      else if (payout > VAL_A_W)
         pay_next = payout - VAL_A_W;
      else
         pay_next = '0;
   end

   // Controller FSM with credit/payout datapath; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         credit      <= '0;
         payout      <= '0;
         vend        <= 1'b0;
         chg_1       <= 1'b0;
         chg_2       <= 1'b0;
         coin_reject <= 1'b0;
         busy        <= 1'b0;
      end else begin
         vend        <= 1'b0;
         chg_1       <= 1'b0;
         chg_2       <= 1'b0;
         coin_reject <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cancel) begin
                  // Cancel has priority; any coin arriving with it goes back.
                  coin_reject <= coin_hit;
                  if (credit != '0) begin
                     payout <= credit;
                     credit <= '0;
                     busy   <= 1'b1;
                     state  <= ST_PAYOUT;
                  end
               end else if (coin_hit) begin
                  coin_reject <= coin_multi;
                  if (sum > MAX_SUM) begin
                     coin_reject <= 1'b1;
                  end else if (sum < PRICE_S) begin
                     credit <= sum[CREDIT_W-1:0];
                  end else begin
                     vend   <= 1'b1;
                     busy   <= 1'b1;
                     credit <= '0;
                     payout <= change[CREDIT_W-1:0];
                     state  <= ST_VEND;
                  end
               end
            end
            ST_VEND: begin
               coin_reject <= coin_hit;
               if (payout == '0) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  state <= ST_PAYOUT;
               end
            end
            ST_PAYOUT: begin
               coin_reject <= coin_hit;
               chg_2       <= pay_big;
               chg_1       <= ~pay_big;
               payout      <= pay_next;
               if (pay_next == '0) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param at default parameters: directed vector table, reset-abort sequence,
// then random pulses compared against a schedule-based reference model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_vend_ctrl_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_a, coin_b, coin_c, cancel;
   logic       vend, chg_1, chg_2, coin_reject, busy;
   logic [3:0] credit;

   always #5 clk = ~clk;

   vend_ctrl_param dut (
      .clk         (clk),
      .rst         (rst),
      .coin_a      (coin_a),
      .coin_b      (coin_b),
      .coin_c      (coin_c),
      .cancel      (cancel),
      .vend        (vend),
      .chg_1       (chg_1),
      .chg_2       (chg_2),
      .coin_reject (coin_reject),
      .busy        (busy),
      .credit      (credit)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Output vector layout: {vend, chg_1, chg_2, coin_reject, busy, credit[3:0]}
   function automatic logic [8:0] outs();
      return {vend, chg_1, chg_2, coin_reject, busy, credit};
   endfunction

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got v/c1/c2/rj/bz/cr=%b required %b", name, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   // Idle-time rules are applied with plain arithmetic; once a vend or refund is
   // decided, its whole future output timeline is appended to a schedule queue.
   typedef struct packed {
      logic v;
      logic c1;
      logic c2;
      logic bz;
   } ev_t;

   int         m_credit;
   ev_t        m_sched[$];
   logic [8:0] m_exp;

   function automatic void m_plan(input bit with_vend, input int owed);
      int n2, n1, m;
      if (with_vend) m_sched.push_back('{v:1'b1, c1:1'b0, c2:1'b0, bz:1'b1});
      if (owed > 0) begin
         n2 = owed / 2;
         n1 = owed % 2;
         m  = n2 + n1;
         m_sched.push_back('{v:1'b0, c1:1'b0, c2:1'b0, bz:1'b1});
         for (int k = 1; k <= m; k++)
            m_sched.push_back('{v:1'b0, c1:(k > n2), c2:(k <= n2), bz:(k < m)});
      end
   endfunction

   function automatic void m_step(input logic a, b, c, cn, r);
      ev_t  e;
      logic rj;
      int   nc, val, s;
      if (r) begin
         m_sched.delete();
         m_credit = 0;
         m_exp    = '0;
         return;
      end
      e  = '0;
      rj = 1'b0;
      nc = int'(a) + int'(b) + int'(c);
      if (m_exp[4]) begin
         rj = (nc > 0);
         if (m_sched.size() > 0) e = m_sched.pop_front();
      end else begin
         if (cn) begin
            rj = (nc > 0);
            if (m_credit > 0) begin
               m_plan(1'b0, m_credit);
               m_credit = 0;
            end
         end else if (nc > 0) begin
            val = c ? 5 : (b ? 2 : 1);
            rj  = (nc > 1);
            s   = m_credit + val;
            if (s > 15) rj = 1'b1;
            else if (s < 5) m_credit = s;
            else begin
               m_plan(1'b1, s - 5);
               m_credit = 0;
            end
         end
         if (m_sched.size() > 0) e = m_sched.pop_front();
      end
      m_exp = {e.v, e.c1, e.c2, rj, e.bz, 4'(m_credit)};
   endfunction

   // One clock: drive inputs, advance the model on the same edge, sample after the edge.
   task automatic tick(input logic a, b, c, cn, r);
      coin_a = a; coin_b = b; coin_c = c; cancel = cn; rst = r;
      @(posedge clk);
      m_step(a, b, c, cn, r);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       a, b, c, cn;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] in, input logic [4:0] fl, input logic [3:0] cr);
      vec_t x;
      x.a = in[3]; x.b = in[2]; x.c = in[1]; x.cn = in[0];
      x.exp = {fl, cr};
      return x;
   endfunction

   initial begin
      coin_a = 0; coin_b = 0; coin_c = 0; cancel = 0; rst = 1;
      m_credit = 0;
      m_exp    = '0;

      // inputs {a,b,c,cancel}, flags {vend,chg_1,chg_2,reject,busy}, credit
      // a,b,b: exact price, no change
      vecs.push_back(mk(4'b1000, 5'b00000, 4'd1));
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd3));
      vecs.push_back(mk(4'b0100, 5'b10001, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00000, 4'd0));
      // b,b,b: one unit of change
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd2));
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd4));
      vecs.push_back(mk(4'b0100, 5'b10001, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00001, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b01000, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00000, 4'd0));
      // b,b,c: sum 9, two 2-unit coins back to back
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd2));
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd4));
      vecs.push_back(mk(4'b0010, 5'b10001, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00001, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00101, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00100, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00000, 4'd0));
      // a,b,cancel: refund 3 as 2 then 1, no vend
      vecs.push_back(mk(4'b1000, 5'b00000, 4'd1));
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd3));
      vecs.push_back(mk(4'b0001, 5'b00001, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00101, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b01000, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00000, 4'd0));
      // a+c at credit 0: vend and reject together
      vecs.push_back(mk(4'b1010, 5'b10011, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00000, 4'd0));
      // a+c at credit 4 (sum 9), coins during VEND and PAYOUT rejected
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd2));
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd4));
      vecs.push_back(mk(4'b1010, 5'b10011, 4'd0));
      vecs.push_back(mk(4'b1000, 5'b00011, 4'd0));
      vecs.push_back(mk(4'b0010, 5'b00111, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00100, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00000, 4'd0));
      // cancel with no credit: no-op, but a coin with it is rejected
      vecs.push_back(mk(4'b0001, 5'b00000, 4'd0));
      vecs.push_back(mk(4'b0101, 5'b00010, 4'd0));
      // cancel beats coin with credit 2
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd2));
      vecs.push_back(mk(4'b1001, 5'b00011, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00100, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00000, 4'd0));
      // a+b: b accepted, a rejected; then reach price exactly
      vecs.push_back(mk(4'b1100, 5'b00010, 4'd2));
      vecs.push_back(mk(4'b0100, 5'b00000, 4'd4));
      vecs.push_back(mk(4'b1000, 5'b10001, 4'd0));
      vecs.push_back(mk(4'b0000, 5'b00000, 4'd0));

      // reset state
      tick(0, 0, 0, 0, 1);
      check("reset", outs(), 9'd0);
      tick(0, 0, 0, 0, 0);
      check("post_reset_idle", outs(), 9'd0);

      foreach (vecs[i]) begin
         tick(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].cn, 1'b0);
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // reset while paying out 4, after the first 2-unit coin
      tick(0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0);
      check("abort_credit4", outs(), {5'b00000, 4'd4});
      tick(0, 0, 0, 1, 0);
      check("abort_cancel", outs(), {5'b00001, 4'd0});
      tick(0, 0, 0, 0, 0);
      check("abort_first_chg2", outs(), {5'b00101, 4'd0});
      tick(0, 0, 0, 0, 1);
      check("abort_reset", outs(), 9'd0);
      for (int k = 0; k < 4; k++) begin
         tick(0, 0, 0, 0, 0);
         check($sformatf("abort_quiet%0d", k), outs(), 9'd0);
      end
      tick(1, 0, 0, 0, 0);
      check("abort_then_coin", outs(), {5'b00000, 4'd1});

      // randomized pulses against the reference model
      tick(0, 0, 0, 0, 1);
      for (int k = 0; k < 4000; k++) begin
         logic ra, rb, rc, rcn, rr;
         ra  = ($urandom_range(0, 3) == 0);
         rb  = ($urandom_range(0, 3) == 0);
         rc  = ($urandom_range(0, 5) == 0);
         rcn = ($urandom_range(0, 9) == 0);
         rr  = ($urandom_range(0, 199) == 0);
         tick(ra, rb, rc, rcn, rr);
         check($sformatf("rand%0d", k), outs(), m_exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
